// File: rtl/lcd_hex_ctrl_if.sv
// lcd_hex_ctrl_if
// Display path between the debug display-select mux and the board LCD pins.
//   data       : 32-bit value to display (driven by the mux side)
//   lcd_e      : LCD enable strobe
//   lcd_rs     : 0 = command byte, 1 = character byte
//   lcd_rw     : read/write select, always write (0)
//   lcd_db     : 8-bit LCD data bus
//   busy       : controller is not idle
//   frame_done : one-cycle pulse when a display frame has been written
// master = the LCD controller, slave = the mux / LCD side.
interface lcd_hex_ctrl_if;
  logic [31:0] data;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_db;
  logic        busy;
  logic        frame_done;

  modport master (
    input  data,
    output lcd_e, lcd_rs, lcd_rw, lcd_db, busy, frame_done
  );

  modport slave (
    output data,
    input  lcd_e, lcd_rs, lcd_rw, lcd_db, busy, frame_done
  );
endinterface

// File: rtl/lcd_hex_ctrl.sv
// lcd_hex_ctrl
// HD44780-compatible character LCD controller (8-bit mode, write-only).
// After reset it waits T_PWRUP cycles, sends the init commands
// 0x38 0x0C 0x06 0x01, then writes the 32-bit input value as eight
// upper-case hex characters at DDRAM address 0. Afterwards it idles and
// rewrites the line only when the input differs from the last shown value.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   lcd_io : lcd_hex_ctrl_if.master (data in; LCD pins, busy, frame_done out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_PWRUP | power-up delay, bus idle
// S_SETUP | one cycle: RS/DB driven, E low
// S_PULSE | E high for T_EN cycles
// S_WAIT  | E low for T_CMD cycles (T_CLR after the clear command)
// S_IDLE  | frame shown; watching data for a change
//
// Byte index: 0..3 init commands, 4 = set DDRAM address 0, 5..12 characters.
module lcd_hex_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 82000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lcd_hex_ctrl_if.master        lcd_io
);

  localparam int MAX_A   = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int MAX_B   = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] IDX_CLR  = 4'd3;
  localparam logic [3:0] IDX_ADDR = 4'd4;
  localparam logic [3:0] IDX_LAST = 4'd12;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic        rs_q, rs_d;
  logic [7:0]  db_q, db_d;
  logic        fd_q, fd_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte for a given index; characters take the snapshot MS nibble first.
  function automatic logic [7:0] byte_for(input logic [3:0] idx, input logic [31:0] snap);
    logic [2:0]  pos;
    logic [7:0]  b;
    pos = 3'(4'd12 - idx);
    case (idx)
      4'd0:    b = 8'h38;
      4'd1:    b = 8'h0C;
      4'd2:    b = 8'h06;
      4'd3:    b = 8'h01;
      4'd4:    b = 8'h80;
      default: b = hex_char(snap[{pos, 2'b00} +: 4]);
    endcase
    return b;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_PWRUP;
      cnt_q   <= CW'(T_PWRUP);
      idx_q   <= 4'd0;
      snap_q  <= 32'h0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    rs_d    = rs_q;
    db_d    = db_q;
    fd_d    = 1'b0;
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = S_SETUP;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = CW'(T_EN - 1);
        if (idx_q == IDX_ADDR) snap_d = lcd_io.data;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = (idx_q == IDX_CLR) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            fd_d    = 1'b1;
          end else begin
            // The clear command rolls straight into the first frame.
            state_d = S_SETUP;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (lcd_io.data != snap_q) begin
          state_d = S_SETUP;
          idx_d   = IDX_ADDR;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // RS/DB are registered on SETUP entry and held through PULSE and WAIT.
    if (state_d == S_SETUP) begin
      rs_d = (idx_d > IDX_ADDR);
      db_d = byte_for(idx_d, snap_q);
    end
  end

  always_comb begin
    lcd_io.lcd_e      = (state_q == S_PULSE);
    lcd_io.lcd_rs     = rs_q;
    lcd_io.lcd_rw     = 1'b0;
    lcd_io.lcd_db     = db_q;
    lcd_io.busy       = (state_q != S_IDLE);
    lcd_io.frame_done = fd_q;
  end

endmodule

// File: tb/tb_lcd_hex_ctrl.sv
// tb_lcd_hex_ctrl
// Bench for lcd_hex_ctrl with short timing parameters. Expected LCD bytes are
// queued when stimulus is applied and popped on every rising edge of E.
module tb_lcd_hex_ctrl;
  localparam int T_PWRUP = 20;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_hex_ctrl_if lcd_if ();

  lcd_hex_ctrl #(
    .T_PWRUP(T_PWRUP),
    .T_EN   (T_EN),
    .T_CMD  (T_CMD),
    .T_CLR  (T_CLR)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .lcd_io(lcd_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [63:0] chars;
  } vec_t;

  vec_t       vecs[6];
  logic [8:0] exp_q[$];
  int         rise_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = -1;
  bit         rst_seen = 1'b0;
  int         n_rise = 0;
  int         fd_cnt = 0;
  int         fd_long = 0;
  int         rw_bad = 0;
  logic       prev_e = 1'b0;
  logic       prev_fd = 1'b0;
  int         e_len = 0;
  logic [8:0] e_bus = '0;
  bit         e_chg = 1'b0;
  logic [8:0] mon_exp;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  always @(posedge clk) begin
    cyc      <= rst ? -1 : cyc + 1;
    rst_seen <= rst;
  end

  // Bus monitor: byte scoreboard plus E-pulse protocol checks.
  always @(negedge clk) begin
    if (lcd_if.lcd_rw !== 1'b0) rw_bad++;
    if (lcd_if.frame_done === 1'b1) begin
      fd_cnt++;
      if (prev_fd === 1'b1) fd_long++;
    end
    if (lcd_if.lcd_e === 1'b1 && prev_e !== 1'b1) begin
      n_rise++;
      rise_q.push_back(cyc);
      e_len = 1;
      e_bus = {lcd_if.lcd_rs, lcd_if.lcd_db};
      e_chg = 1'b0;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_byte", 64'({lcd_if.lcd_rs, lcd_if.lcd_db}), 64'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check({lcd_if.lcd_rs, lcd_if.lcd_db} === mon_exp, "byte",
              64'({lcd_if.lcd_rs, lcd_if.lcd_db}), 64'(mon_exp));
      end
    end else if (lcd_if.lcd_e === 1'b1) begin
      e_len++;
      if ({lcd_if.lcd_rs, lcd_if.lcd_db} !== e_bus) e_chg = 1'b1;
    end else if (prev_e === 1'b1 && !rst_seen) begin
      check(e_len == T_EN && !e_chg, "e_pulse", 64'({e_chg, 32'(e_len)}), 64'(T_EN));
    end
    prev_e  = lcd_if.lcd_e;
    prev_fd = lcd_if.frame_done;
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [63:0] chars);
    exp_q.push_back({1'b0, 8'h80});
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, chars[63-8*k -: 8]});
  endtask

  // Asserts reset for one edge (from the current negedge if now=1).
  task automatic do_reset(input bit now);
    if (!now) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({lcd_if.lcd_e, lcd_if.lcd_rs, lcd_if.lcd_rw, lcd_if.lcd_db, lcd_if.busy, lcd_if.frame_done}
          === {3'b000, 8'h00, 2'b10}, "reset_state",
          64'({lcd_if.lcd_e, lcd_if.lcd_rs, lcd_if.lcd_rw, lcd_if.lcd_db, lcd_if.busy, lcd_if.frame_done}),
          64'({3'b000, 8'h00, 2'b10}));
    rst = 1'b0;
    exp_q.delete();
    rise_q.delete();
    n_rise = 0;
    fd_cnt = 0;
    push_init();
  endtask

  task automatic wait_fd(input int budget, output int c);
    int n;
    n = 0;
    c = -1;
    while (n < budget && c < 0) begin
      @(negedge clk);
      n++;
      if (lcd_if.frame_done === 1'b1) c = cyc;
    end
    if (c < 0) check(1'b0, "frame_done_timeout", 64'(n), 64'(budget));
  endtask

  task automatic wait_rise(input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && n_rise < target) begin
      @(negedge clk);
      n++;
    end
    if (n_rise < target) check(1'b0, "rise_timeout", 64'(n_rise), 64'(target));
  endtask

  task automatic check_init_timing();
    if (rise_q.size() >= 5) begin
      check(rise_q[0] == 21, "first_e_rise", 64'(rise_q[0]), 64'd21);
      check(rise_q[3] == 45, "clear_e_rise", 64'(rise_q[3]), 64'd45);
      check(rise_q[4] == 58, "clear_wait_len", 64'(rise_q[4] - rise_q[3]), 64'd13);
    end else begin
      check(1'b0, "init_rise_count", 64'(rise_q.size()), 64'd5);
    end
  endtask

  initial begin : main
    int setup_c, fd_c, exp_fd, f1, f2;
    vecs[0] = '{data: 32'h1234ABCD, chars: 64'h31323334_41424344};
    vecs[1] = '{data: 32'hDEADBEEF, chars: 64'h44454144_42454546};
    vecs[2] = '{data: 32'h89ABCDEF, chars: 64'h38394142_43444546};
    vecs[3] = '{data: 32'h0F1E2D3C, chars: 64'h30463145_32443343};
    vecs[4] = '{data: 32'h00000000, chars: 64'h30303030_30303030};
    vecs[5] = '{data: 32'hFFFFFFFF, chars: 64'h46464646_46464646};
    lcd_if.data = 32'h0;

    // Power-up, init, first frame, then change-triggered frames.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        lcd_if.data = vecs[0].data;
        do_reset(1'b0);
        push_frame(vecs[0].chars);
        exp_fd = 129;
      end else begin
        @(negedge clk);
        lcd_if.data = vecs[i].data;
        push_frame(vecs[i].chars);
        @(negedge clk);
        setup_c = cyc;
        check({lcd_if.busy, lcd_if.lcd_e, lcd_if.lcd_rs, lcd_if.lcd_db} === {3'b100, 8'h80},
              "change_setup", 64'({lcd_if.busy, lcd_if.lcd_e, lcd_if.lcd_rs, lcd_if.lcd_db}),
              64'({3'b100, 8'h80}));
        exp_fd = setup_c + 72;
      end
      wait_fd(2000, fd_c);
      check(fd_c == exp_fd, "frame_done_cycle", 64'(fd_c), 64'(exp_fd));
      check(exp_q.size() == 0, "frame_bytes_left", 64'(exp_q.size()), 64'd0);
      if (i == 0) begin
        check_init_timing();
        repeat (20) @(negedge clk);
        check(lcd_if.busy === 1'b0 && n_rise == 13 && fd_cnt == 1, "idle_hold",
              64'({lcd_if.busy, 16'(n_rise), 16'(fd_cnt)}), 64'({1'b0, 16'd13, 16'd1}));
      end
    end

    // Data change during the third character of a frame.
    lcd_if.data = 32'h0;
    do_reset(1'b0);
    push_frame(vecs[4].chars);
    wait_rise(8, 500);
    lcd_if.data = 32'hFFFFFFFF;
    push_frame(vecs[5].chars);
    wait_fd(2000, f1);
    check(f1 == 129, "midchange_fd1", 64'(f1), 64'd129);
    wait_fd(2000, f2);
    check(f2 == f1 + 73, "midchange_fd2", 64'(f2), 64'(f1 + 73));
    check(exp_q.size() == 0, "midchange_bytes_left", 64'(exp_q.size()), 64'd0);

    // Reset while E is high during init, then a clean restart.
    lcd_if.data = 32'h0;
    do_reset(1'b0);
    wait_rise(2, 500);
    do_reset(1'b1);
    push_frame(vecs[4].chars);
    wait_fd(2000, fd_c);
    check(fd_c == 129, "restart_frame_done", 64'(fd_c), 64'd129);
    check_init_timing();
    check(exp_q.size() == 0, "restart_bytes_left", 64'(exp_q.size()), 64'd0);

    repeat (5) @(negedge clk);
    check(rw_bad == 0, "rw_low", 64'(rw_bad), 64'd0);
    check(fd_long == 0, "frame_done_width", 64'(fd_long), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/lcd_hex_ctrl.md
# lcd_hex_ctrl

Sequential HD44780-compatible character-LCD controller that physically displays the 32-bit value chosen by the debug display selector. It runs the controller power-up/initialisation sequence and then writes the value as eight upper-case hex characters on line 1. It refreshes only when the value changes. It sits between the display-select mux output and the board LCD pins, and is the transmitting end of that display path.

## Interface
- T_PWRUP, 750000, idle cycles after reset before the first command (15 ms @ 50 MHz)
- T_EN, 12, cycles LCD_E is held high per byte
- T_CMD, 2500, post-pulse wait cycles for every byte except clear (50 µs)
- T_CLR, 82000, post-pulse wait cycles after the clear command (1.64 ms)

- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- Data  in  32  value to display; sampled only at frame start
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = character data
- LCD_RW  out  1  constant 0 (write-only)
- LCD_DB  out  8  LCD data bus, 8-bit mode
- Busy  out  1  1 while not in IDLE
- Frame_done  out  1  one-cycle pulse when a display frame completes

## Operation
- Top states: PWRUP → INIT → FRAME → IDLE.
- PWRUP:
  - Count T_PWRUP cycles with E=0, RS=0, DB=0.
  - Then enter INIT.
- INIT sends four commands in order:
  - 0x38: function set, 8-bit, 2 lines
  - 0x0C: display on, cursor off
  - 0x06: entry mode, increment
  - 0x01: clear display
- FRAME sends nine bytes:
  - Command 0x80: DDRAM address 0.
  - Eight data bytes (RS=1): hex digits of the snapshot, Data[31:28] first, Data[3:0] last.
- Hex encoding: nibble 0–9 → 0x30–0x39; nibble A–F → 0x41–0x46 (upper case).
- Snapshot register:
  - Loads Data in the SETUP cycle of the 0x80 byte.
  - Data changes during a frame do not affect that frame.
- IDLE:
  - Compares Data with the snapshot every cycle.
  - If they differ, the next cycle is the SETUP of a new FRAME.
  - If they are equal, the block stays in IDLE.
- The first FRAME after INIT always runs, whatever the snapshot holds.
- Byte sub-FSM, identical for every byte:
  - SETUP (1 cycle): drive RS and DB; E=0.
  - PULSE (T_EN cycles): E=1; RS and DB held.
  - WAIT (T_CMD cycles, or T_CLR for 0x01): E=0; RS and DB held.
- A single down-counter, wide enough for the largest parameter, serves PWRUP, PULSE and WAIT.
- Counter loads happen on state entry, so the counts are exact.

## Timing
- Reset values (the cycle after RST is sampled high):
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0x00
  - Busy=1, Frame_done=0, snapshot=0, state=PWRUP
- RST mid-operation:
  - Takes effect at the next edge from any state, including mid-PULSE.
  - E drops immediately, and the full power-up sequence restarts.
- Cycle numbering: cycle 0 is the first rising edge with RST low.
  - PWRUP occupies cycles 0..T_PWRUP−1.
  - The SETUP of the first INIT byte is at cycle T_PWRUP.
- Byte cost: 1+T_EN+T_CMD cycles, or 1+T_EN+T_CLR for the clear.
- INIT length: 3·(1+T_EN+T_CMD) + (1+T_EN+T_CLR).
- FRAME length: 9·(1+T_EN+T_CMD).
- Frame_done:
  - High for exactly one cycle: the first cycle after the last WAIT.
  - In that cycle the FSM is in IDLE, so Busy=0.
- Change detected in the Frame_done cycle: the next cycle is the 0x80 SETUP, with Busy=1.
- Minimum idle between frames: 1 cycle.
- LCD_RW is never 1. DB and RS never change while E=1.

## Test plan
Parameters for all tests: T_PWRUP=20, T_EN=2, T_CMD=5, T_CLR=10.

1. Power-up and init: reset, Data=0.
   - E stays 0 through cycle 19.
   - First E rise at cycle 21 with DB=0x38, RS=0.
   - Bytes follow in order 0x38, 0x0C, 0x06, 0x01.
   - The clear byte's WAIT lasts 10 cycles.
2. First frame: Data=0x1234ABCD held constant.
   - Captured byte stream after init: 0x80 (RS=0), then 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 (RS=1).
   - Frame_done pulses once at cycle 129.
   - The block then stays in IDLE with Busy=0 and no further E pulses.
3. Change detection: after test 2, set Data=0xDEADBEEF.
   - The next cycle is a SETUP with DB=0x80.
   - Characters sent: 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46.
   - Frame_done pulses 72 cycles after that SETUP.
4. Mid-frame change: change Data from 0x00000000 to 0xFFFFFFFF during the third character.
   - The current frame completes with all characters 0x30.
   - An immediate second frame follows with all characters 0x46.
5. Reset mid-pulse: assert RST while E=1 during INIT.
   - Next cycle: E=0, DB=0, Busy=1.
   - After RST is released, the full sequence repeats with the same timing as test 1.
6. Bus stability (protocol checker, all tests):
   - RW=0 at all times.
   - RS and DB are stable whenever E=1.
   - Every E-high interval is exactly 2 cycles.
